// File: rtl/instr_aligner_if.sv
// Fetch-buffer / decoder handshake bundle for instr_aligner.
// master = aligner side, slave = fetch buffer plus decoder side.
interface instr_aligner_if #(
   parameter int ERR_W = 3
);
   logic             flush;
   logic [31:0]      fetch;
   logic             fetch_valid;
   logic             fetch_hw1;
   logic [ERR_W-1:0] fetch_error;
   logic [1:0]       fetch_pred;
   logic             fetch_ready;
   logic [31:0]      instr;
   logic             valid;
   logic             ready;
   logic [ERR_W-1:0] instr_error;
   logic             align_error;
   logic             prediction;

   modport master (
      input  flush, fetch, fetch_valid, fetch_hw1, fetch_error, fetch_pred, ready,
      output fetch_ready, instr, valid, instr_error, align_error, prediction
   );

   modport slave (
      output flush, fetch, fetch_valid, fetch_hw1, fetch_error, fetch_pred, ready,
      input  fetch_ready, instr, valid, instr_error, align_error, prediction
   );
endinterface

// File: rtl/instr_aligner.sv
// Turns 32-bit fetch words into aligned RVI/RVC instructions behind a registered valid/ready output.
// Define RVC_ALIGN_EN for halfword alignment; without it every fetch word passes through verbatim.
module instr_aligner #(
   parameter int ERR_W = 3
) (
   input logic             clk,
   input logic             rst,
   instr_aligner_if.master bus
);

   typedef struct packed {
      logic [31:0]      instr;
      logic [ERR_W-1:0] err;
      logic             align;
      logic             pred;
   } out_t;

   function automatic out_t mk_out(input logic [31:0] instr, input logic [ERR_W-1:0] err,
                                   input logic align, input logic pred);
      out_t o;
      o.instr = instr;
      o.err   = err;
      o.align = align;
      o.pred  = pred;
      return o;
   endfunction

   logic load_ok;
   logic emit;
   logic consume;
   logic first_hw1;
   logic valid_q;
   out_t out_nxt;
   out_t out_q;

   // A stall is the only thing that blocks the output register.
   assign load_ok = ~valid_q | bus.ready;

`ifdef RVC_ALIGN_EN
   logic [15:0]      hb;
   logic             hb_v;
   logic [ERR_W-1:0] hb_err;
   logic             hb_pred;
   logic             hb_load;
   logic             hb_v_nxt;
   logic [15:0]      lo;
   logic [15:0]      hi;

   assign lo = bus.fetch[15:0];
   assign hi = bus.fetch[31:16];

   function automatic logic is_rvc(input logic [15:0] hw);
      return hw[1:0] != 2'b11;
   endfunction

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      emit     = 1'b0;
      consume  = 1'b0;
      hb_load  = 1'b0;
      hb_v_nxt = hb_v;
      out_nxt  = '0;
      if (load_ok) begin
         if (first_hw1) begin
            // Redirect into halfword 1: the low half is not part of the program.
            if (bus.fetch_valid) begin
               consume = 1'b1;
               if (is_rvc(hi)) begin
                  emit     = 1'b1;
                  out_nxt  = mk_out({16'h0, hi}, bus.fetch_error, 1'b0, bus.fetch_pred[1]);
                  hb_v_nxt = 1'b0;
               end else begin
                  hb_load  = 1'b1;
                  hb_v_nxt = 1'b1;
               end
            end
         end else if (hb_v && is_rvc(hb)) begin
            emit     = 1'b1;
            out_nxt  = mk_out({16'h0, hb}, hb_err, 1'b0, hb_pred);
            hb_v_nxt = 1'b0;
         end else if (hb_v) begin
            if (bus.fetch_valid) begin
               consume  = 1'b1;
               emit     = 1'b1;
               out_nxt  = mk_out({lo, hb}, (hb_err != '0) ? hb_err : bus.fetch_error,
                                 hb_pred, ~hb_pred & bus.fetch_pred[0]);
               hb_load  = 1'b1;
               hb_v_nxt = ~(hb_pred | bus.fetch_pred[0]);
            end
         end else if (bus.fetch_valid) begin
            consume = 1'b1;
            emit    = 1'b1;
            if (is_rvc(lo)) begin
               out_nxt  = mk_out({16'h0, lo}, bus.fetch_error, 1'b0, bus.fetch_pred[0]);
               hb_load  = 1'b1;
               hb_v_nxt = ~bus.fetch_pred[0];
            end else begin
               out_nxt  = mk_out(bus.fetch, bus.fetch_error, bus.fetch_pred[0],
                                 ~bus.fetch_pred[0] & bus.fetch_pred[1]);
               hb_v_nxt = 1'b0;
            end
         end
      end
   end

   // NOTE: the halfword payload carries no reset; hb_v alone says whether it is meaningful.
   always_ff @(posedge clk) begin
      if (hb_load) begin
         hb      <= hi;
         hb_err  <= bus.fetch_error;
         hb_pred <= bus.fetch_pred[1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst || bus.flush) hb_v <= 1'b0;
      else                  hb_v <= hb_v_nxt;
   end

   assign bus.fetch_ready = ~rst & ~bus.flush & consume;
`else
   always_comb begin
      consume = load_ok & bus.fetch_valid;
      emit    = bus.fetch_valid;
      out_nxt = mk_out(bus.fetch, bus.fetch_error, bus.fetch_pred[0] | first_hw1,
                       bus.fetch_pred[1]);
   end

   assign bus.fetch_ready = ~rst & ~bus.flush & load_ok;
`endif

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q   <= 1'b0;
         out_q     <= '0;
         first_hw1 <= 1'b0;
      end else if (bus.flush) begin
         valid_q   <= 1'b0;
         first_hw1 <= bus.fetch_hw1;
      end else begin
         if (load_ok) begin
            valid_q <= emit;
            if (emit) out_q <= out_nxt;
         end
         if (consume) first_hw1 <= 1'b0;
      end
   end

   assign bus.valid       = valid_q;
   assign bus.instr       = out_q.instr;
   assign bus.instr_error = out_q.err;
   assign bus.align_error = out_q.align;
   assign bus.prediction  = out_q.pred;

endmodule
